// File: rtl/intr_dispatch_pkg.sv
// intr_dispatch_pkg: dispatcher state encodings and manager trigger-type codes
package intr_dispatch_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, CLEAR = 2'd2, GAP = 2'd3} state_t;
  localparam logic [1:0] TRIG_LEVEL = 2'd0;
  localparam logic [1:0] TRIG_RISE  = 2'd1;
  localparam logic [1:0] TRIG_FALL  = 2'd2;
  localparam logic [1:0] TRIG_BOTH  = 2'd3;
endpackage

// File: rtl/intr_prio_enc.sv
// intr_prio_enc: fixed-priority encoder, lowest set index wins
module intr_prio_enc #(
  parameter int INTR_NUM = 8,
  parameter int ID_W = 3
) (
  input  logic [INTR_NUM-1:0] req,
  output logic                any,
  output logic [ID_W-1:0]     id
);
  always_comb begin
    any = |req;
    id = '0;
    for (int i = INTR_NUM - 1; i >= 0; i--) if (req[i]) id = ID_W'(i);
  end
endmodule

// File: rtl/intr_dispatch.sv
// intr_dispatch: masks pending flags, offers one ID over valid/ack, clears it, then holds off
module intr_dispatch
  import intr_dispatch_pkg::*;
#(
  parameter int INTR_NUM = 8,
  parameter int ID_W = 3,
  parameter int HOLDOFF = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [INTR_NUM-1:0] intr_sig,
  input  logic [INTR_NUM-1:0] intr_en,
  output logic                irq_valid,
  output logic [ID_W-1:0]     irq_id,
  input  logic                irq_ack,
  output logic                intr_clr,
  output logic [INTR_NUM-1:0] intr_clr_sel,
  output logic                busy
);
  localparam int CW = HOLDOFF > 0 ? $clog2(HOLDOFF + 1) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(HOLDOFF > 0 ? HOLDOFF - 1 : 0);
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [ID_W-1:0] id, id_n, enc_id;
  logic any;
  intr_prio_enc #(.INTR_NUM(INTR_NUM), .ID_W(ID_W)) u_enc (
    .req(intr_sig & intr_en),
    .any(any),
    .id(enc_id)
  );
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    id_n = id;
    case (state)
      IDLE: if (any) begin
        state_n = SEND;
        id_n = enc_id;
      end
      SEND: if (irq_ack) state_n = CLEAR;
      CLEAR: begin
        state_n = HOLDOFF == 0 ? IDLE : GAP;
        cnt_n = CNT_INIT;
      end
      GAP: begin
        state_n = cnt == '0 ? IDLE : GAP;
        cnt_n = cnt == '0 ? cnt : cnt - 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end
  // outputs are registered from the next state so they align with the state they describe
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      id <= '0;
      irq_valid <= 1'b0;
      irq_id <= '0;
      intr_clr <= 1'b0;
      intr_clr_sel <= '0;
      busy <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      id <= id_n;
      irq_valid <= state_n == SEND;
      irq_id <= id_n;
      intr_clr <= state_n == CLEAR;
      intr_clr_sel <= state_n == CLEAR ? INTR_NUM'(1) << id_n : '0;
      busy <= state_n != IDLE;
    end
  end
endmodule

// File: tb/tb_intr_dispatch.sv
// tb_intr_dispatch: randomized and directed checks against a cooldown-based dispatcher model
module tb_intr_dispatch;
  localparam int H = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] intr_sig = '0;
  logic [7:0] intr_en = 8'hFF;
  logic irq_valid;
  logic [2:0] irq_id;
  logic irq_ack = 1'b0;
  logic intr_clr;
  logic [7:0] intr_clr_sel;
  logic busy;
  logic [7:0] pend = '0;
  int m_offer = -1;
  int m_wait = 0;
  logic [7:0] m_sel = '0;
  int n_pass = 0;
  int n_total = 0;
  bit done = 1'b0;

  intr_dispatch #(.INTR_NUM(8), .ID_W(3), .HOLDOFF(H)) dut (
    .clk(clk),
    .rst(rst),
    .intr_sig(intr_sig),
    .intr_en(intr_en),
    .irq_valid(irq_valid),
    .irq_id(irq_id),
    .irq_ack(irq_ack),
    .intr_clr(intr_clr),
    .intr_clr_sel(intr_clr_sel),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // dispatcher seen as: one offer at a time, then a cooldown of CLEAR plus HOLDOFF cycles
  task automatic model_adv(input logic r, input logic a, input logic [7:0] sig, input logic [7:0] en);
    logic [7:0] act;
    act = sig & en;
    m_sel = '0;
    if (r) begin
      m_offer = -1;
      m_wait = 0;
    end else if (m_offer >= 0) begin
      if (a) begin
        m_sel = 8'(1 << m_offer);
        m_offer = -1;
        m_wait = H + 1;
      end
    end else if (m_wait > 0) begin
      m_wait--;
    end else if (act != 0) begin
      for (int i = 7; i >= 0; i--) if (act[i]) m_offer = i;
    end
  endtask

  always @(posedge clk) begin
    #2;
    if (!done) begin
      chk("irq_valid", irq_valid, m_offer >= 0);
      if (m_offer >= 0) chk("irq_id", irq_id, m_offer);
      chk("intr_clr", intr_clr, m_sel != 0);
      chk("intr_clr_sel", intr_clr_sel, m_sel);
      chk("busy", busy, m_offer >= 0 || m_wait > 0);
    end
  end

  // called at a negedge: drives this cycle's inputs, manager drops flags on an un-reset clear
  task automatic step(input logic r, input logic a, input logic [7:0] en, input logic [7:0] raise);
    rst = r;
    irq_ack = a;
    intr_en = en;
    if (intr_clr && !r) pend &= ~intr_clr_sel;
    pend |= raise;
    intr_sig = pend;
    model_adv(r, a, pend, en);
    @(negedge clk);
  endtask

  task automatic do_reset();
    pend = '0;
    step(1'b1, 1'b0, 8'hFF, 8'h00);
    step(1'b1, 1'b0, 8'hFF, 8'h00);
  endtask

  task automatic wait_valid(input int max, input logic [7:0] en);
    for (int i = 0; i < max && !irq_valid; i++) step(1'b0, 1'b0, en, 8'h00);
    chk("wait_valid", irq_valid, 1'b1);
  endtask

  initial begin
    int nclr;
    @(negedge clk);
    step(1'b1, 1'b0, 8'hFF, 8'hFF);
    step(1'b1, 1'b0, 8'hFF, 8'h00);
    step(1'b1, 1'b0, 8'hFF, 8'h00);
    chk("rst_valid", irq_valid, 1'b0);
    chk("rst_clr", intr_clr, 1'b0);
    chk("rst_busy", busy, 1'b0);
    step(1'b0, 1'b0, 8'hFF, 8'h00);
    chk("first_valid", irq_valid, 1'b1);
    chk("first_id", irq_id, 0);
    do_reset();
    step(1'b0, 1'b0, 8'hFB, 8'hA4);
    chk("mask_id", irq_id, 5);
    step(1'b0, 1'b1, 8'hFB, 8'h00);
    chk("mask_clr", intr_clr, 1'b1);
    chk("mask_sel", intr_clr_sel, 8'h20);
    step(1'b0, 1'b0, 8'hFB, 8'h00);
    chk("clr_one_cycle", intr_clr, 1'b0);
    step(1'b0, 1'b0, 8'hFB, 8'h00);
    step(1'b0, 1'b0, 8'hFB, 8'h00);
    chk("holdoff_low", irq_valid, 1'b0);
    step(1'b0, 1'b0, 8'hFB, 8'h00);
    chk("holdoff_next", irq_valid, 1'b1);
    chk("holdoff_id", irq_id, 7);
    step(1'b0, 1'b0, 8'hFF, 8'h01);
    chk("stable_id", irq_id, 7);
    step(1'b0, 1'b1, 8'hFF, 8'h00);
    wait_valid(12, 8'hFF);
    chk("preempt_next", irq_id, 0);
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 8'hFF, 8'h00);
      chk("idle_ack_busy", busy, 1'b0);
    end
    do_reset();
    nclr = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b1, 8'hFF, i == 0 ? 8'h13 : 8'h00);
      if (intr_clr) nclr++;
    end
    chk("ack_held_count", nclr, 3);
    do_reset();
    step(1'b0, 1'b0, 8'hFF, 8'h08);
    step(1'b0, 1'b1, 8'hFF, 8'h00);
    chk("pre_rst_clr", intr_clr, 1'b1);
    step(1'b1, 1'b0, 8'hFF, 8'h00);
    chk("rst_drops_clr", intr_clr, 1'b0);
    wait_valid(6, 8'hFF);
    chk("redispatch_id", irq_id, 3);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(99) == 0, 1'($urandom_range(1)), $urandom_range(3) == 0 ? 8'($urandom) : 8'hFF,
           $urandom_range(2) == 0 ? 8'(1 << $urandom_range(7)) : 8'h00);
    done = 1'b1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
